// File: rtl/hamming_corrector.sv
// Hamming(7,4) single-error corrector with a 2-entry output FIFO.
// Define HAMMING_STATS_EN to build the word/correction counters; otherwise they read 0.
module hamming_corrector (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        out_corrected,
  output logic [2:0]  out_syndrome,
  input  logic        stats_clr,
  output logic [15:0] word_cnt,
  output logic [15:0] corr_cnt
);

  logic [2:0] syndrome;
  logic [6:0] fixedCode;
  logic [7:0] entry;
  logic [7:0] head;
  logic [7:0] entries_q [2];
  logic       rdPtr_q;
  logic       wrPtr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push;
  logic       pop;

  assign syndrome = {in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6],
                     in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6],
                     in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6]};

  // Any nonzero syndrome is trusted as a single-bit error position.
  always_comb begin
    fixedCode = in_code;
    if (syndrome != 3'd0) begin
      fixedCode[syndrome - 3'd1] = ~in_code[syndrome - 3'd1];
    end
  end

  assign entry = {fixedCode[6], fixedCode[5], fixedCode[4], fixedCode[2],
                  (syndrome != 3'd0), syndrome};

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q[0] <= '0;
      entries_q[1] <= '0;
      rdPtr_q      <= 1'b0;
      wrPtr_q      <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      if (push) begin
        entries_q[wrPtr_q] <= entry;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

  assign head          = out_valid ? entries_q[rdPtr_q] : 8'd0;
  assign out_data      = head[7:4];
  assign out_corrected = head[3];
  assign out_syndrome  = head[2:0];

`ifdef HAMMING_STATS_EN
  logic [15:0] wordCnt_q;
  logic [15:0] wordCnt_d;
  logic [15:0] corrCnt_q;
  logic [15:0] corrCnt_d;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    wordCnt_d = wordCnt_q;
    corrCnt_d = corrCnt_q;
    if (stats_clr) begin
      wordCnt_d = 16'd0;
      corrCnt_d = 16'd0;
    end else if (push) begin
      if (wordCnt_q != 16'hFFFF) begin
        wordCnt_d = wordCnt_q + 16'd1;
      end
      if ((syndrome != 3'd0) && (corrCnt_q != 16'hFFFF)) begin
        corrCnt_d = corrCnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wordCnt_q <= 16'd0;
      corrCnt_q <= 16'd0;
    end else begin
      wordCnt_q <= wordCnt_d;
      corrCnt_q <= corrCnt_d;
    end
  end

  assign word_cnt = wordCnt_q;
  assign corr_cnt = corrCnt_q;
`else
  logic unusedStats;
  assign unusedStats = stats_clr;
  assign word_cnt    = 16'd0;
  assign corr_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_hamming_corrector.sv
// Directed self-checking bench for hamming_corrector; expectations adapt to HAMMING_STATS_EN.
module tb_hamming_corrector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_code;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_corrected;
  logic [2:0]  out_syndrome;
  logic        stats_clr;
  logic [15:0] word_cnt;
  logic [15:0] corr_cnt;

  int checks = 0;
  int errors = 0;

`ifdef HAMMING_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  localparam logic [6:0] CodeClean13 = 7'b1100110;
  localparam logic [6:0] CodeErr0    = 7'b1100111;
  localparam logic [6:0] CodeErr6    = 7'b1000111;
  localparam logic [6:0] CodeDouble  = 7'b1100101;
  localparam logic [6:0] Code3       = 7'b0011110;
  localparam logic [6:0] Code5       = 7'b0101101;
  localparam logic [6:0] Code9       = 7'b1001100;

  hamming_corrector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_corrected (out_corrected),
    .out_syndrome  (out_syndrome),
    .stats_clr     (stats_clr),
    .word_cnt      (word_cnt),
    .corr_cnt      (corr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [6:0] code, input logic ready, input logic clr);
    in_valid  = valid;
    in_code   = code;
    out_ready = ready;
    stats_clr = clr;
  endtask

  initial begin
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset word_cnt", word_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", in_ready, 1);

    // Clean word, latency 1
    applyStimulus(1'b1, CodeClean13, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("clean out_valid", out_valid, 1);
    checkOutput("clean out_data", out_data, 13);
    checkOutput("clean syndrome", out_syndrome, 0);
    checkOutput("clean corrected", out_corrected, 0);
    applyStimulus(1'b1, CodeErr0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("err0 out_data", out_data, 13);
    checkOutput("err0 syndrome", out_syndrome, 1);
    checkOutput("err0 corrected", out_corrected, 1);
    applyStimulus(1'b1, CodeErr6, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("err6 out_data", out_data, 1);
    checkOutput("err6 syndrome", out_syndrome, 7);
    checkOutput("err6 corrected", out_corrected, 1);
    applyStimulus(1'b1, CodeDouble, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("double miscorrect data", out_data, 12);
    checkOutput("double syndrome", out_syndrome, 3);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drained out_valid", out_valid, 0);
    checkOutput("idle out_data zero", out_data, 0);
    checkOutput("idle syndrome zero", out_syndrome, 0);

    // Backpressure: 3, 5 fill the FIFO, 9 waits
    applyStimulus(1'b1, Code3, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp in_ready after 1", in_ready, 1);
    checkOutput("bp head 3", out_data, 3);
    applyStimulus(1'b1, Code5, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp in_ready full", in_ready, 0);
    applyStimulus(1'b1, Code9, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp still full", in_ready, 0);
    checkOutput("bp head held", out_data, 3);
    checkOutput("bp valid held", out_valid, 1);
    applyStimulus(1'b1, Code9, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp drain 5", out_data, 5);
    checkOutput("bp ready after pop", in_ready, 1);
    @(negedge clk);
    checkOutput("bp push+pop gives 9", out_data, 9);
    checkOutput("bp valid 9", out_valid, 1);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp empty", out_valid, 0);

    // Counters
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("clr word_cnt", word_cnt, 0);
    checkOutput("clr corr_cnt", corr_cnt, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, (i < 4) ? CodeClean13 : CodeErr0, 1'b1, 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    checkOutput("last corrected flag", out_corrected, 1);
    @(negedge clk);
    checkOutput("cnt word 7", word_cnt, StatsOn ? 7 : 0);
    checkOutput("cnt corr 3", corr_cnt, StatsOn ? 3 : 0);
    applyStimulus(1'b1, CodeErr0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    checkOutput("clr prio word", word_cnt, 0);
    checkOutput("clr prio corr", corr_cnt, 0);
    checkOutput("clr push data", out_data, 13);
    @(negedge clk);
    applyStimulus(1'b1, CodeErr0, 1'b1, 1'b0);
    repeat (65537) @(negedge clk);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("sat corr_cnt", corr_cnt, StatsOn ? 16'hFFFF : 0);
    checkOutput("sat word_cnt", word_cnt, StatsOn ? 16'hFFFF : 0);

    // Asynchronous reset with a full FIFO
    applyStimulus(1'b1, CodeClean13, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
    checkOutput("pre-reset full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", out_valid, 0);
    checkOutput("async rst in_ready", in_ready, 1);
    checkOutput("async rst out_data", out_data, 0);
    checkOutput("async rst word_cnt", word_cnt, 0);
    checkOutput("async rst corr_cnt", corr_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after rst in_ready", in_ready, 1);
    checkOutput("after rst out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_corrector.md
HAMMING_CORRECTOR -- requirements
Module: hamming_corrector

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: in_code is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a codeword.
REQ-005 SHALL have port in_code, input, 7 bits: received Hamming(7,4) codeword, bit [k] = code position k+1.
REQ-006 SHALL have port out_valid, output, 1 bit: output head entry is valid.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts the head entry.
REQ-008 SHALL have port out_data, output, 4 bits: corrected data nibble.
REQ-009 SHALL have port out_corrected, output, 1 bit: syndrome was nonzero and one bit was flipped.
REQ-010 SHALL have port out_syndrome, output, 3 bits: raw syndrome {s4,s2,s1}.
REQ-011 SHALL have port stats_clr, input, 1 bit: synchronous clear of statistics counters.
REQ-012 SHALL have port word_cnt, output, 16 bits: codewords accepted (saturating).
REQ-013 SHALL have port corr_cnt, output, 16 bits: codewords with nonzero syndrome (saturating).

Function
REQ-014 SHALL compute s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s4=c3^c4^c5^c6, where c = in_code.
REQ-015 SHALL, for syndrome S != 0, invert in_code[S-1]; for S = 0, SHALL pass the codeword unchanged.
REQ-016 SHALL extract data = {c6,c5,c4,c2} from the corrected codeword.
REQ-017 SHALL treat every nonzero syndrome as a single-bit error; double errors are miscorrected by design and carry no separate flag.
REQ-018 SHALL buffer results in a 2-entry FIFO; a push occurs on in_valid && in_ready.
REQ-019 SHALL drive in_ready = (occupancy < 2), with no combinational path from out_ready or in_valid.
REQ-020 SHALL present an accepted codeword's result on out_* in the cycle after acceptance when the FIFO was empty (latency 1).
REQ-021 SHALL pop the head on out_valid && out_ready.
REQ-022 SHALL support a simultaneous push and pop at occupancy 1, leaving occupancy at 1.
REQ-023 SHALL hold out_data, out_corrected and out_syndrome stable while out_valid && !out_ready.
REQ-024 SHALL preserve first-in, first-out order.
REQ-025 SHALL drive out_data, out_corrected and out_syndrome to 0 when out_valid = 0.
REQ-026 SHALL increment word_cnt on each push, and corr_cnt on each push with S != 0; each counter SHALL saturate at 16'hFFFF.
REQ-027 SHALL give stats_clr priority over a same-cycle increment, so the counters become 0.

Reset
REQ-028 SHALL, on rst_n low and at any time including mid-transfer, immediately empty the FIFO and set out_valid=0, in_ready=1, and out_data, out_corrected, out_syndrome, word_cnt and corr_cnt to 0.
REQ-029 SHALL discard any in-flight codewords at reset; in_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-030 SHALL include the word_cnt/corr_cnt counter logic when macro HAMMING_STATS_EN is defined, behaving per REQ-026 and REQ-027.
REQ-031 SHALL, without HAMMING_STATS_EN, keep all ports, tie word_cnt and corr_cnt to 0 and ignore stats_clr; all datapath behaviour SHALL be identical.

Verification
REQ-032 Clean word: in_code=7'b1100110, out_ready=1 -> next cycle out_valid=1, out_data=4'd13, out_syndrome=0, out_corrected=0.
REQ-033 Single error: in_code=7'b1100111 (bit 0 flipped) -> out_data=4'd13, out_syndrome=3'd1, out_corrected=1; 7'b1000111 -> out_data=4'd1, out_syndrome=3'd7.
REQ-034 Backpressure: out_ready=0, offer codes for 3, 5, 9 back-to-back -> in_ready low after the 2nd accept; raising out_ready drains 3, 5, then accepts and outputs 9, in order.
REQ-035 Counters (HAMMING_STATS_EN): 4 clean + 3 corrupted words -> word_cnt=7, corr_cnt=3; stats_clr during a corrupted push -> both 0; 65537 corrupted words -> corr_cnt=16'hFFFF.
REQ-036 Reset mid-operation: FIFO holding 2 entries, rst_n low -> out_valid=0, in_ready=1, counters 0 immediately, without waiting for a clock edge.
REQ-037 Macro off: run the REQ-035 stimulus -> word_cnt=corr_cnt=0, and the data outputs match the REQ-032 to REQ-034 results.
